// File: rtl/dpram_arb_pkg.sv
// Shared types and default widths for the dual-port RAM port arbiter.
// Structs carry maximum-width fields so any legal parameterisation fits.
package dpram_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int WR_LATENCY_DEF = 1;
    localparam int RD_LATENCY_DEF = 1;
    localparam int MAX_ID_WIDTH   = 3;
    localparam int MAX_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ID_WIDTH-1:0]   id;
    } rd_pipe_t;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] addr;
    } wr_track_t;

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational round-robin search: first eligible requester at or after ptr.
// The pointer register itself lives in the parent.
module rr_priority_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  eligible,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] next_ptr
);

    int   idx;
    logic found;

    // Rotating priority search; pointer holds when nothing is granted
    always_comb begin
        gnt      = {NUM_REQ{1'b0}};
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ((int'(ptr) + i) >= NUM_REQ) ? (int'(ptr) + i - NUM_REQ) : (int'(ptr) + i);
            if (!found && eligible[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = (idx == NUM_REQ - 1) ? {ID_WIDTH{1'b0}} : ID_WIDTH'(idx + 1);
                found    = 1'b1;
            end else begin
                found    = found;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with drain/halt.
// DPRAM_ARB_RAW_STALL_EN compiles in the write tracker that stalls reads hitting recent writes.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int WR_LATENCY = WR_LATENCY_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_din,
    input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    input  logic                          i_drain,
    output logic                          o_idle
);

    arb_state_e            state;
    arb_state_e            state_next;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic [ID_WIDTH-1:0]   port_id;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [NUM_REQ-1:0]    blocked;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gnt_any;
    logic                  grant_allowed;
    logic                  pipe_busy;
    logic                  trk_busy;
    rd_pipe_t              rd_pipe [RD_LATENCY];

`ifdef DPRAM_ARB_RAW_STALL_EN
    wr_track_t             wr_track [WR_LATENCY];
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  hit;

    // Read-after-write hazard: compare each read against the port write and tracker
    always_comb begin
        blocked  = {NUM_REQ{1'b0}};
        req_addr = {ADDR_WIDTH{1'b0}};
        hit      = 1'b0;
        trk_busy = o_mem_en && o_mem_we;
        for (int i = 0; i < WR_LATENCY; i++) begin
            trk_busy = trk_busy || wr_track[i].valid;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            req_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            hit      = o_mem_en && o_mem_we && (o_mem_addr == req_addr);
            for (int i = 0; i < WR_LATENCY; i++) begin
                hit = hit || (wr_track[i].valid &&
                              (wr_track[i].addr == MAX_ADDR_WIDTH'(req_addr)));
            end
            blocked[k] = !i_we[k] && hit;
        end
    end

    // Write tracker shifts each port write through the commit window
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WR_LATENCY; i++) begin
                wr_track[i] <= '0;
            end
        end else begin
            wr_track[0] <= {o_mem_en && o_mem_we, MAX_ADDR_WIDTH'(o_mem_addr)};
            for (int i = 1; i < WR_LATENCY; i++) begin
                wr_track[i] <= wr_track[i-1];
            end
        end
    end
`else
    assign blocked  = {NUM_REQ{1'b0}};
    assign trk_busy = 1'b0;
`endif

    assign grant_allowed = (state == RUN) && !i_drain && !rst;
    assign eligible      = i_req & ~blocked & {NUM_REQ{grant_allowed}};

    rr_priority_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .gnt      (gnt),
        .next_ptr (ptr_next)
    );

    assign o_gnt   = gnt;
    assign gnt_any = |gnt;

    // Encode the one-hot grant into an index
    always_comb begin
        gnt_idx = {ID_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_idx = gnt_idx | (gnt[k] ? ID_WIDTH'(k) : {ID_WIDTH{1'b0}});
        end
    end

    // Register the granted command onto the memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= {ADDR_WIDTH{1'b0}};
            o_mem_din  <= {DATA_WIDTH{1'b0}};
            port_id    <= {ID_WIDTH{1'b0}};
        end else if (gnt_any) begin
            o_mem_en   <= 1'b1;
            o_mem_we   <= i_we[gnt_idx];
            o_mem_addr <= i_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            o_mem_din  <= i_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            port_id    <= gnt_idx;
        end else begin
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
        end
    end

    // Read pipe tracks the owner of each read until its data returns
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= {o_mem_en && !o_mem_we, MAX_ID_WIDTH'(port_id)};
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // A read still on the port counts as in flight
    always_comb begin
        pipe_busy = o_mem_en && !o_mem_we;
        for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_busy = pipe_busy || rd_pipe[i].valid;
        end
    end

    // Response routing from the pipe head
    always_comb begin
        o_rvalid = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            o_rvalid[k] = rd_pipe[RD_LATENCY-1].valid &&
                          (rd_pipe[RD_LATENCY-1].id == MAX_ID_WIDTH'(k));
        end
    end

    assign o_rdata = i_mem_rdata;
    assign o_idle  = (state == HALT);

    // Drain/halt state transitions
    always_comb begin
        case (state)
            RUN:     state_next = i_drain ? DRAIN : RUN;
            DRAIN:   state_next = (!pipe_busy && !trk_busy) ? HALT : DRAIN;
            HALT:    state_next = i_drain ? HALT : RUN;
            default: state_next = RUN;
        endcase
    end

    // State and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ptr   <= {ID_WIDTH{1'b0}};
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed self-checking bench for dpram_port_arbiter with a small latency RAM model.
module tb_dpram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, we;
    logic [15:0] addr;
    logic [31:0] din;
    logic        drain;
    logic [3:0]  gnt, rvalid;
    logic        mem_en, mem_we, idle;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_din, mem_rdata, rdata;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  last_gnt;
    logic        hold;
    logic [7:0]  mem [16];
    logic        pend_v;
    logic [3:0]  pend_a;
    logic [7:0]  pend_d;
    logic [3:0]  eg   [11];
    logic [3:0]  erv  [11];
    logic        eidl [11];
    int          rd_c;
    logic [7:0]  rd_v;

    always #5 clk = ~clk;

    dpram_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_din       (din),
        .o_gnt       (gnt),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_din   (mem_din),
        .i_mem_rdata (mem_rdata),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .i_drain     (drain),
        .o_idle      (idle)
    );

    // RAM model: read data one cycle after command, write commits a cycle after the port
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h30 + 8'(i);
            pend_v    <= 1'b0;
            mem_rdata <= 8'h00;
        end else begin
            if (pend_v) mem[pend_a] <= pend_d;
            pend_v <= mem_en && mem_we;
            pend_a <= mem_addr;
            pend_d <= mem_din;
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        if (!hold) req = req & ~last_gnt;
    endtask

    task automatic expect_cyc(input string tag, input logic [3:0] eg_i, input logic [3:0] erv_i);
        #4;
        check({tag, "_gnt"}, gnt, eg_i);
        check({tag, "_rvalid"}, rvalid, erv_i);
        last_gnt = gnt;
    endtask

    task automatic set_rq(input int k, input logic w, input logic [3:0] a, input logic [7:0] d);
        req[k]          = 1'b1;
        we[k]           = w;
        addr[k*4 +: 4]  = a;
        din[k*8 +: 8]   = d;
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; din = '0; drain = 1'b0;
        hold = 1'b0; last_gnt = '0;

        // Reset state, with requests pending that must not be granted
        next();
        for (int k = 0; k < 4; k++) set_rq(k, 1'b0, 4'(k), 8'h00);
        expect_cyc("reset", 4'h0, 4'h0);
        check("reset_mem_en", mem_en, 1'b0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_mem_addr", mem_addr, 4'h0);
        check("reset_mem_din", mem_din, 8'h00);
        check("reset_idle", idle, 1'b0);

        // All four read addresses 0..3 at once
        next();
        rst = 1'b0;
        eg  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        erv = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next();
            expect_cyc($sformatf("rr_c%0d", c), eg[c], erv[c]);
            if (erv[c] != 4'h0) check($sformatf("rr_rdata_c%0d", c), rdata, 32'h2E + c);
            if (c == 0) check("rr_mem_en_c0", mem_en, 1'b0);
            if (c == 1) check("rr_mem_en_c1", {mem_en, mem_we, mem_addr}, 6'b10_0000);
        end

        // Write 0xA5 to addr 5 by requester 1 against a read of addr 5 by requester 2
        next();
        set_rq(1, 1'b1, 4'h5, 8'hA5);
        set_rq(2, 1'b0, 4'h5, 8'h00);
`ifdef DPRAM_ARB_RAW_STALL_EN
        eg  = '{4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        erv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        rd_c = 5; rd_v = 8'hA5;
`else
        eg  = '{4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        erv = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        rd_c = 3; rd_v = 8'h35;
`endif
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next();
            expect_cyc($sformatf("raw_c%0d", c), eg[c], erv[c]);
            if (c == 1) check("raw_port_wr", {mem_en, mem_we, mem_addr, mem_din}, 14'b11_0101_10100101);
            if (c == rd_c) check("raw_rdata", rdata, rd_v);
        end

        // Read addr 3 and write addr 7 do not conflict
        next();
        set_rq(0, 1'b0, 4'h3, 8'h00);
        set_rq(3, 1'b1, 4'h7, 8'h5C);
        eg  = '{4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        erv = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next();
            expect_cyc($sformatf("nohz_c%0d", c), eg[c], erv[c]);
            if (c == 1) check("nohz_port_wr", {mem_en, mem_we, mem_addr}, 6'b11_0111);
            if (c == 3) check("nohz_rdata", rdata, 8'h33);
        end

        // Requesters 0 and 2 hold requests; 2 drops out, then 0
        next();
        hold = 1'b1;
        set_rq(0, 1'b0, 4'h0, 8'h00);
        set_rq(2, 1'b0, 4'h2, 8'h00);
        eg  = '{4'h4, 4'h1, 4'h4, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        erv = '{4'h0, 4'h0, 4'h4, 4'h1, 4'h4, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next();
            if (c == 4) req[2] = 1'b0;
            if (c == 6) req[0] = 1'b0;
            expect_cyc($sformatf("alt_c%0d", c), eg[c], erv[c]);
        end
        hold = 1'b0;

        // Drain with two reads in flight, then resume
        next();
        set_rq(1, 1'b0, 4'h1, 8'h00);
        set_rq(2, 1'b0, 4'h2, 8'h00);
        eg   = '{4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
        erv  = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
        eidl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next();
            if (c == 2) begin
                drain = 1'b1;
                set_rq(3, 1'b0, 4'h3, 8'h00);
            end
            if (c == 7) drain = 1'b0;
            expect_cyc($sformatf("drain_c%0d", c), eg[c], erv[c]);
            check($sformatf("drain_idle_c%0d", c), idle, eidl[c]);
            if (c == 2) check("drain_rdata_c2", rdata, 8'h31);
            if (c == 3) check("drain_rdata_c3", rdata, 8'h32);
            if (c == 10) check("drain_rdata_c10", rdata, 8'h33);
        end

        // Reset one cycle after a read grant to requester 2
        next();
        set_rq(2, 1'b0, 4'h2, 8'h00);
        expect_cyc("rst_c0", 4'h4, 4'h0);
        next();
        rst = 1'b1;
        set_rq(1, 1'b0, 4'h1, 8'h00);
        set_rq(3, 1'b0, 4'h3, 8'h00);
        expect_cyc("rst_c1", 4'h0, 4'h0);
        next();
        expect_cyc("rst_c2", 4'h0, 4'h0);
        check("rst_c2_mem_en", mem_en, 1'b0);
        next();
        rst = 1'b0;
        expect_cyc("rst_c3", 4'h2, 4'h0);
        check("rst_c3_mem_en", mem_en, 1'b0);
        next();
        expect_cyc("rst_c4", 4'h8, 4'h0);
        check("rst_c4_port", {mem_en, mem_we, mem_addr}, 6'b10_0001);
        next();
        expect_cyc("rst_c5", 4'h0, 4'h2);
        check("rst_c5_rdata", rdata, 8'h31);
        next();
        expect_cyc("rst_c6", 4'h0, 4'h8);
        check("rst_c6_rdata", rdata, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
